// File: rtl/xsleena_cpu_cen_sched.sv
// Clock-enable scheduler for the three 6x09 CPUs (main, sub, sound) and the
// FM chip. CPU E/Q quadrature advances one phase per 6 MHz hclk slot, so CPU
// timing stays locked to video. Each CPU can be stretched at the end of its
// bus cycle for SDRAM ROM waits, and all CPUs can be parked at a bus-cycle
// boundary for the OSD pause handshake.
//
// Per-CPU phase state:
//   state      | meaning
//   PH_Q_RISE  | bus cycle boundary; next slot raises Q (or parks while paused)
//   PH_E_RISE  | Q high; next slot raises E
//   PH_Q_FALL  | Q and E high; next slot drops Q
//   PH_E_FALL  | E high; next slot drops E unless the ROM wait stretches it

module xsleena_cpu_cen_sched #(
    parameter int FM_NUM   = 179,
    parameter int FM_DEN   = 2400,
    parameter int WAIT_MAX = 255
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_hclk_cen,
    input  logic [2:0] i_wait,
    input  logic       i_pause,
    output logic [2:0] o_q_rise,
    output logic [2:0] o_e_rise,
    output logic [2:0] o_q_fall,
    output logic [2:0] o_e_fall,
    output logic [2:0] o_e,
    output logic [2:0] o_q,
    output logic       o_fm_cen,
    output logic       o_pause_ack,
    output logic [2:0] o_wait_timeout
);

    typedef enum logic [1:0] {
        PH_Q_RISE = 2'd0,
        PH_E_RISE = 2'd1,
        PH_Q_FALL = 2'd2,
        PH_E_FALL = 2'd3
    } phase_t;

    localparam logic [7:0]  WAIT_LIM  = 8'(WAIT_MAX);
    localparam logic [16:0] FM_NUM_W  = 17'(FM_NUM);
    localparam logic [16:0] FM_DEN_W  = 17'(FM_DEN);

    phase_t     ph            [3];
    phase_t     ph_nxt        [3];
    logic [7:0] stall_cnt     [3];
    logic [7:0] stall_cnt_nxt [3];

    logic [2:0] halted, halted_nxt;
    logic [2:0] q_rise_nxt, e_rise_nxt, q_fall_nxt, e_fall_nxt;
    logic [2:0] e_nxt, q_nxt, timeout_nxt;
    logic       pause_ack_nxt;

    logic [15:0] fm_acc, fm_acc_nxt;
    logic [16:0] fm_sum;
    logic        fm_cen_nxt;

    // Phase, stretch and pause decisions for each CPU on hclk slots.
    always_comb begin
        halted_nxt  = halted;
        q_rise_nxt  = '0;
        e_rise_nxt  = '0;
        q_fall_nxt  = '0;
        e_fall_nxt  = '0;
        e_nxt       = o_e;
        q_nxt       = o_q;
        timeout_nxt = o_wait_timeout;
        for (int i = 0; i < 3; i++) begin
            ph_nxt[i]        = ph[i];
            stall_cnt_nxt[i] = stall_cnt[i];
        end

        if (i_hclk_cen) begin
            for (int i = 0; i < 3; i++) begin
                case (ph[i])
                    PH_Q_RISE: begin
                        // A parked CPU sits here with E=Q=0 until pause drops.
                        if (i_pause) begin
                            halted_nxt[i] = 1'b1;
                        end else begin
                            halted_nxt[i] = 1'b0;
                            q_rise_nxt[i] = 1'b1;
                            q_nxt[i]      = 1'b1;
                            ph_nxt[i]     = PH_E_RISE;
                        end
                    end
                    PH_E_RISE: begin
                        e_rise_nxt[i] = 1'b1;
                        e_nxt[i]      = 1'b1;
                        ph_nxt[i]     = PH_Q_FALL;
                    end
                    PH_Q_FALL: begin
                        q_fall_nxt[i] = 1'b1;
                        q_nxt[i]      = 1'b0;
                        ph_nxt[i]     = PH_E_FALL;
                    end
                    PH_E_FALL: begin
                        // Wait wins over pause: the cycle must finish first.
                        if (i_wait[i]) begin
                            if (stall_cnt[i] < WAIT_LIM) begin
                                stall_cnt_nxt[i] = stall_cnt[i] + 8'd1;
                            end
                            if (stall_cnt_nxt[i] >= WAIT_LIM) begin
                                timeout_nxt[i] = 1'b1;
                            end
                        end else begin
                            e_fall_nxt[i]    = 1'b1;
                            e_nxt[i]         = 1'b0;
                            stall_cnt_nxt[i] = 8'd0;
                            ph_nxt[i]        = PH_Q_RISE;
                        end
                    end
                    default: ph_nxt[i] = PH_Q_RISE;
                endcase
            end
        end

        pause_ack_nxt = (&halted) & i_pause;
    end

    // Fractional FM enable: accumulate FM_NUM per unpaused clock, wrap at FM_DEN.
    always_comb begin
        fm_sum     = {1'b0, fm_acc} + FM_NUM_W;
        fm_acc_nxt = fm_acc;
        fm_cen_nxt = 1'b0;
        if (!i_pause) begin
            if (fm_sum >= FM_DEN_W) begin
                fm_acc_nxt = 16'(fm_sum - FM_DEN_W);
                fm_cen_nxt = 1'b1;
            end else begin
                fm_acc_nxt = fm_sum[15:0];
            end
        end
    end

    // State and registered outputs; reset drops everything, including stretches.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 3; i++) begin
                ph[i]        <= PH_Q_RISE;
                stall_cnt[i] <= 8'd0;
            end
            halted         <= '0;
            o_q_rise       <= '0;
            o_e_rise       <= '0;
            o_q_fall       <= '0;
            o_e_fall       <= '0;
            o_e            <= '0;
            o_q            <= '0;
            o_wait_timeout <= '0;
            o_pause_ack    <= 1'b0;
            fm_acc         <= 16'd0;
            o_fm_cen       <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                ph[i]        <= ph_nxt[i];
                stall_cnt[i] <= stall_cnt_nxt[i];
            end
            halted         <= halted_nxt;
            o_q_rise       <= q_rise_nxt;
            o_e_rise       <= e_rise_nxt;
            o_q_fall       <= q_fall_nxt;
            o_e_fall       <= e_fall_nxt;
            o_e            <= e_nxt;
            o_q            <= q_nxt;
            o_wait_timeout <= timeout_nxt;
            o_pause_ack    <= pause_ack_nxt;
            fm_acc         <= fm_acc_nxt;
            o_fm_cen       <= fm_cen_nxt;
        end
    end

endmodule

// File: tb/tb_xsleena_cpu_cen_sched.sv
// Bench for the CPU/FM clock-enable scheduler: a behavioural model checked
// every cycle, plus directed scenarios with hand-computed expectations.

module tb_xsleena_cpu_cen_sched;

    localparam int NUM  = 179;
    localparam int DEN  = 2400;
    localparam int WMAX = 255;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       hclk  = 1'b0;
    logic       pause = 1'b0;
    logic [2:0] wt    = 3'b000;

    logic [2:0] o_q_rise, o_e_rise, o_q_fall, o_e_fall, o_e, o_q, o_wait_timeout;
    logic       o_fm_cen, o_pause_ack;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    xsleena_cpu_cen_sched #(.FM_NUM(NUM), .FM_DEN(DEN), .WAIT_MAX(WMAX)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_hclk_cen    (hclk),
        .i_wait        (wt),
        .i_pause       (pause),
        .o_q_rise      (o_q_rise),
        .o_e_rise      (o_e_rise),
        .o_q_fall      (o_q_fall),
        .o_e_fall      (o_e_fall),
        .o_e           (o_e),
        .o_q           (o_q),
        .o_fm_cen      (o_fm_cen),
        .o_pause_ack   (o_pause_ack),
        .o_wait_timeout(o_wait_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // hclk: every 8th clock, or random slots in the soak phase
    bit hrand = 1'b0;
    int hcnt  = 0;
    initial forever begin
        @(negedge clk);
        if (hrand) begin
            hclk = ($urandom_range(0, 3) == 0);
        end else begin
            hclk = (hcnt == 0);
            hcnt = (hcnt + 1) % 8;
        end
    end

    // ---------------- behavioural model ----------------
    // done[i] counts bus-cycle events emitted since reset; the event due next
    // is done%4 (Q rise, E rise, Q fall, E fall) and the levels follow from it.
    int         done  [3];
    int         stall [3];
    bit         halted[3];
    bit   [2:0] m_tmo;
    longint     fm_n;
    logic [2:0] x_qr, x_er, x_qf, x_ef;
    logic       x_fm, x_ack;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            done[i] = 0; stall[i] = 0; halted[i] = 1'b0;
        end
        m_tmo = 3'b000; fm_n = 0;
        x_qr = '0; x_er = '0; x_qf = '0; x_ef = '0; x_fm = 1'b0; x_ack = 1'b0;
    endtask

    task automatic model_step();
        x_ack = halted[0] && halted[1] && halted[2] && pause;
        x_qr = '0; x_er = '0; x_qf = '0; x_ef = '0;
        if (hclk) begin
            for (int i = 0; i < 3; i++) begin
                int pos;
                pos = done[i] % 4;
                if (pos == 0 && pause) begin
                    halted[i] = 1'b1;
                end else if (pos == 3 && wt[i]) begin
                    if (stall[i] < WMAX) stall[i]++;
                    if (stall[i] >= WMAX) m_tmo[i] = 1'b1;
                end else begin
                    halted[i] = 1'b0;
                    case (pos)
                        0: x_qr[i] = 1'b1;
                        1: x_er[i] = 1'b1;
                        2: x_qf[i] = 1'b1;
                        default: begin x_ef[i] = 1'b1; stall[i] = 0; end
                    endcase
                    done[i]++;
                end
            end
        end
        x_fm = 1'b0;
        if (!pause) begin
            fm_n++;
            x_fm = ((fm_n * NUM) / DEN) != (((fm_n - 1) * NUM) / DEN);
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    function automatic logic [22:0] dut_vec();
        return {o_q_rise, o_e_rise, o_q_fall, o_e_fall, o_e, o_q,
                o_fm_cen, o_pause_ack, o_wait_timeout};
    endfunction

    function automatic logic [22:0] model_vec();
        logic [2:0] e, q;
        for (int i = 0; i < 3; i++) begin
            int pos;
            pos  = done[i] % 4;
            q[i] = (pos == 1) || (pos == 2);
            e[i] = (pos == 2) || (pos == 3);
        end
        return {x_qr, x_er, x_qf, x_ef, e, q, x_fm, x_ack, m_tmo};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // every-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        chk("model_outputs", int'(dut_vec()), int'(model_vec()));
    end

    function automatic logic get_bit(input int sel, input int cpu);
        case (sel)
            0:       return o_q_rise[cpu];
            1:       return o_e_rise[cpu];
            2:       return o_q_fall[cpu];
            3:       return o_e_fall[cpu];
            default: return o_pause_ack;
        endcase
    endfunction

    // bounded wait on an output bit; returns the cycle it was seen
    task automatic wait_bit(input int sel, input int cpu, input int limit, output int when);
        when = -1;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (get_bit(sel, cpu)) begin
                when = cyc;
                break;
            end
        end
        checks++;
        if (when < 0) begin
            errors++;
            $display("FAIL wait_sel%0d_cpu%0d actual timeout required event within %0d cycles",
                     sel, cpu, limit);
        end
    endtask

    // one full unstalled bus cycle on main, all CPUs aligned
    task automatic seq_check(input string tag);
        int t0, t1, t2, t3, t4;
        wait_bit(0, 0, 40, t0);
        chk({tag, "_qrise_all"}, int'(o_q_rise), 7);
        chk({tag, "_tmo_clear"}, int'(o_wait_timeout), 0);
        wait_bit(1, 0, 16, t1);
        chk({tag, "_qr_to_er"}, t1 - t0, 8);
        wait_bit(2, 0, 16, t2);
        chk({tag, "_er_to_qf"}, t2 - t1, 8);
        wait_bit(3, 0, 16, t3);
        chk({tag, "_efall_all"}, int'(o_e_fall), 7);
        chk({tag, "_qf_to_ef"}, t3 - t2, 8);
        wait_bit(0, 0, 16, t4);
        chk({tag, "_period"}, t4 - t0, 32);
    endtask

    task automatic fm_window(input int pause_at, input int pause_len,
                             output int pulses, output int adj);
        int  u, pcnt;
        bit  prev;
        u = 0; pcnt = 0; prev = 1'b0; pulses = 0; adj = 0;
        while (u < DEN) begin
            @(negedge clk);
            if (!pause) begin
                u++;
                if (o_fm_cen) pulses++;
                if (prev && o_fm_cen) adj++;
                prev = o_fm_cen;
            end else if (o_fm_cen) begin
                adj++;
            end
            if (!pause && pause_len > 0 && u == pause_at) begin
                pause = 1'b1; pcnt = pause_len;
            end else if (pause) begin
                pcnt--;
                if (pcnt == 0) pause = 1'b0;
            end
        end
    endtask

    initial begin
        int tq, te, ta, fmc, pulses, adj;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'(dut_vec()), 0);
        rst_n = 1'b1;

        // 1: free-running sequence
        seq_check("s1");

        // 2: main stretched for 3 slots
        wait_bit(2, 0, 40, tq);
        wt[0] = 1'b1;
        repeat (8) @(negedge clk);
        chk("s2_others_efall", int'(o_e_fall), 6);
        chk("s2_main_e_high", int'(o_e[0]), 1);
        repeat (16) @(negedge clk);
        wt[0] = 1'b0;
        wait_bit(3, 0, 40, te);
        chk("s2_stretch_gap", te - tq, 32);
        chk("s2_no_timeout", int'(o_wait_timeout), 0);

        // 3: pause while main is in ph1
        wait_bit(0, 0, 40, tq);
        pause = 1'b1;
        fmc = 0; ta = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (o_fm_cen) fmc++;
            if (o_pause_ack) begin ta = cyc; break; end
        end
        chk("s3_ack_latency", ta - tq, 33);
        repeat (20) begin
            @(negedge clk);
            if (o_fm_cen) fmc++;
        end
        chk("s3_ack_held", int'(o_pause_ack), 1);
        chk("s3_levels_low", int'({o_e, o_q}), 0);
        chk("s3_fm_silent", fmc, 0);
        pause = 1'b0;
        @(negedge clk);
        chk("s3_ack_clear", int'(o_pause_ack), 0);
        wait_bit(0, 0, 16, te);
        chk("s3_resume_all", int'(o_q_rise), 7);

        // 4: FM rate, unpaused and with a pause inside the window
        fm_window(0, 0, pulses, adj);
        chk("s4_fm_count", pulses, NUM);
        chk("s4_fm_adjacent", adj, 0);
        fm_window(1000, 200, pulses, adj);
        chk("s4_fm_count_paused", pulses, NUM);
        chk("s4_fm_adjacent_paused", adj, 0);

        // 5: sub stretched long enough to time out
        wait_bit(2, 1, 40, tq);
        wt[1] = 1'b1;
        while (cyc < tq + 8 * (WMAX - 1) + 7) @(negedge clk);
        chk("s5_tmo_before", int'(o_wait_timeout[1]), 0);
        while (cyc < tq + 8 * WMAX) @(negedge clk);
        chk("s5_tmo_set", int'(o_wait_timeout[1]), 1);
        chk("s5_sub_e_high", int'(o_e[1]), 1);
        while (cyc < tq + 8 * 260 + 1) @(negedge clk);
        wt[1] = 1'b0;
        wait_bit(3, 1, 20, te);
        chk("s5_efall_gap", te - tq, 8 * 261);
        chk("s5_tmo_sticky", int'(o_wait_timeout), 2);

        // 6a: reset in the middle of a stretch
        wait_bit(2, 2, 40, tq);
        wt[2] = 1'b1;
        repeat (12) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("s6_async_rst_stretch", int'(dut_vec()), 0);
        wt = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        seq_check("s6a");

        // 6b: reset while paused
        wait_bit(0, 0, 40, tq);
        pause = 1'b1;
        wait_bit(4, 0, 100, ta);
        #2 rst_n = 1'b0;
        #1 chk("s6_async_rst_pause", int'(dut_vec()), 0);
        pause = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seq_check("s6b");

        // soak: random hclk, waits and pause
        hrand = 1'b1;
        for (int k = 0; k < 6000; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++)
                if ($urandom_range(0, 15) == 0) wt[i] = ~wt[i];
            if ($urandom_range(0, 149) == 0) pause = ~pause;
        end
        wt = 3'b000; pause = 1'b0;
        repeat (40) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

endmodule
